// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings and helpers for the fetch/load-store memory
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_WAIT = 2'd2;

  // Transaction owner encoding
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Instruction fetches always read the full word
  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_REQ  = ARB_REQ,
    ST_WAIT = ARB_WAIT
  } arbState_t;

  // Round-robin pick: on a tie the side that did not win last time goes next
  function automatic logic pickOwner(input logic iReq, input logic dReq,
                                     input logic lastGrant);
    if (iReq && dReq) begin
      return ~lastGrant;
    end else if (dReq) begin
      return OWN_D;
    end else begin
      return OWN_I;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : arb_watchdog
// Description : Saturating response-wait counter with synchronous clear and
//               count enable; flags when the threshold has been reached.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int CNTW           = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstN,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // Expiry is judged on the count before this cycle's increment, so the
  // flag fires during the TIMEOUT_CYCLES-th counted cycle.
  localparam logic [CNTW-1:0] C_LAST = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNTW-1:0] C_MAX  = '1;

  logic [CNTW-1:0] r_count;

  // Saturating counter: clear dominates, then count while enabled
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count >= C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one single-ported memory bus
//               between the instruction-fetch and load/store ports, with one
//               transaction outstanding and a response watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNTW           = 8
) (
  input  logic                 ARB_Clk_In,
  input  logic                 ARB_Reset_In,
  input  logic                 ARB_I_Req_In,
  input  logic [DATAWIDTH-1:0] ARB_I_Addr_InBUS,
  output logic                 ARB_I_Valid_Out,
  output logic [DATAWIDTH-1:0] ARB_I_Readdata_OutBUS,
  input  logic                 ARB_D_Req_In,
  input  logic                 ARB_D_Write_In,
  input  logic [DATAWIDTH-1:0] ARB_D_Addr_InBUS,
  input  logic [DATAWIDTH-1:0] ARB_D_Writedata_InBUS,
  input  logic [3:0]           ARB_D_Byteenable_InBUS,
  output logic                 ARB_D_Ready_Out,
  output logic                 ARB_D_Valid_Out,
  output logic [DATAWIDTH-1:0] ARB_D_Readdata_OutBUS,
  output logic                 ARB_Mem_Req_Out,
  output logic                 ARB_Mem_We_Out,
  output logic [DATAWIDTH-1:0] ARB_Mem_Addr_OutBUS,
  output logic [DATAWIDTH-1:0] ARB_Mem_Writedata_OutBUS,
  output logic [3:0]           ARB_Mem_Byteenable_OutBUS,
  input  logic                 ARB_Mem_Gnt_In,
  input  logic                 ARB_Mem_Rvalid_In,
  input  logic [DATAWIDTH-1:0] ARB_Mem_Readdata_InBUS,
  output logic                 ARB_Error_Out
);

  arbState_t            r_state;
  arbState_t            w_nextState;
  logic                 r_owner;
  logic                 r_lastGrant;
  logic                 r_we;
  logic [DATAWIDTH-1:0] r_addr;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [3:0]           r_be;
  logic                 r_iValid;
  logic                 r_dValid;
  logic                 r_dReady;
  logic [DATAWIDTH-1:0] r_iRdata;
  logic [DATAWIDTH-1:0] r_dRdata;
  logic                 r_error;

  logic w_grant;
  logic w_owner;
  logic w_respond;
  logic w_timeout;
  logic w_wdClear;
  logic w_wdEnable;
  logic w_expired;

  arb_watchdog #(
    .CNTW           (CNTW),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (ARB_Clk_In),
    .rstN      (ARB_Reset_In),
    .i_clear   (w_wdClear),
    .i_enable  (w_wdEnable),
    .o_expired (w_expired)
  );

  // FSM state register
  always_ff @(posedge ARB_Clk_In) begin
    if (!ARB_Reset_In) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; a response arriving in the expiry cycle beats the timeout
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_owner     = pickOwner(ARB_I_Req_In, ARB_D_Req_In, r_lastGrant);
    w_respond   = 1'b0;
    w_timeout   = 1'b0;
    w_wdClear   = 1'b0;
    w_wdEnable  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ARB_I_Req_In || ARB_D_Req_In) begin
          w_grant     = 1'b1;
          w_nextState = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ARB_Mem_Gnt_In) begin
          w_wdClear   = 1'b1;
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ARB_Mem_Rvalid_In) begin
          w_respond   = 1'b1;
          w_nextState = ST_IDLE;
        end else begin
          w_wdEnable = 1'b1;
          if (w_expired) begin
            w_timeout   = 1'b1;
            w_nextState = ST_IDLE;
          end
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Bus payload capture on grant, registered response pulses and sticky error
  always_ff @(posedge ARB_Clk_In) begin
    if (!ARB_Reset_In) begin
      r_owner     <= OWN_I;
      r_lastGrant <= OWN_D;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_iValid    <= 1'b0;
      r_dValid    <= 1'b0;
      r_dReady    <= 1'b0;
      r_iRdata    <= '0;
      r_dRdata    <= '0;
      r_error     <= 1'b0;
    end else begin
      r_iValid <= 1'b0;
      r_dValid <= 1'b0;
      r_dReady <= 1'b0;
      if (w_grant) begin
        r_owner     <= w_owner;
        r_lastGrant <= w_owner;
        if (w_owner == OWN_D) begin
          r_we    <= ARB_D_Write_In;
          r_addr  <= ARB_D_Addr_InBUS;
          r_wdata <= ARB_D_Writedata_InBUS;
          r_be    <= ARB_D_Byteenable_InBUS;
        end else begin
          r_we    <= 1'b0;
          r_addr  <= ARB_I_Addr_InBUS;
          r_wdata <= '0;
          r_be    <= BE_ALL;
        end
      end
      if (w_respond) begin
        if (r_owner == OWN_I) begin
          r_iValid <= 1'b1;
          r_iRdata <= ARB_Mem_Readdata_InBUS;
        end else if (r_we) begin
          r_dReady <= 1'b1;
        end else begin
          r_dValid <= 1'b1;
          r_dRdata <= ARB_Mem_Readdata_InBUS;
        end
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign ARB_Mem_Req_Out           = (r_state == ST_REQ);
  assign ARB_Mem_We_Out            = r_we;
  assign ARB_Mem_Addr_OutBUS       = r_addr;
  assign ARB_Mem_Writedata_OutBUS  = r_wdata;
  assign ARB_Mem_Byteenable_OutBUS = r_be;
  assign ARB_I_Valid_Out           = r_iValid;
  assign ARB_I_Readdata_OutBUS     = r_iRdata;
  assign ARB_D_Valid_Out           = r_dValid;
  assign ARB_D_Ready_Out           = r_dReady;
  assign ARB_D_Readdata_OutBUS     = r_dRdata;
  assign ARB_Error_Out             = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstN;
  logic          iReq;
  logic [DW-1:0] iAddr;
  logic          dReq;
  logic          dWrite;
  logic [DW-1:0] dAddr;
  logic [DW-1:0] dWdata;
  logic [3:0]    dBe;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  logic          iValid;
  logic [DW-1:0] iRdata;
  logic          dReady;
  logic          dValid;
  logic [DW-1:0] dRdata;
  logic          memReq;
  logic          memWe;
  logic [DW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [3:0]    memBe;
  logic          error;

  int assertCount = 0;
  int failCount   = 0;

  mem_port_arbiter #(
    .DATAWIDTH      (DW),
    .TIMEOUT_CYCLES (4),
    .CNTW           (8)
  ) dut (
    .ARB_Clk_In                (clk),
    .ARB_Reset_In              (rstN),
    .ARB_I_Req_In              (iReq),
    .ARB_I_Addr_InBUS          (iAddr),
    .ARB_I_Valid_Out           (iValid),
    .ARB_I_Readdata_OutBUS     (iRdata),
    .ARB_D_Req_In              (dReq),
    .ARB_D_Write_In            (dWrite),
    .ARB_D_Addr_InBUS          (dAddr),
    .ARB_D_Writedata_InBUS     (dWdata),
    .ARB_D_Byteenable_InBUS    (dBe),
    .ARB_D_Ready_Out           (dReady),
    .ARB_D_Valid_Out           (dValid),
    .ARB_D_Readdata_OutBUS     (dRdata),
    .ARB_Mem_Req_Out           (memReq),
    .ARB_Mem_We_Out            (memWe),
    .ARB_Mem_Addr_OutBUS       (memAddr),
    .ARB_Mem_Writedata_OutBUS  (memWdata),
    .ARB_Mem_Byteenable_OutBUS (memBe),
    .ARB_Mem_Gnt_In            (gnt),
    .ARB_Mem_Rvalid_In         (rvalid),
    .ARB_Mem_Readdata_InBUS    (rdata),
    .ARB_Error_Out             (error)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0; iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWrite = 1'b0;
    dAddr = '0; dWdata = '0; dBe = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    step(); step();

    // Reset state
    checkVal("rst_memReq", {31'b0, memReq}, 32'd0);
    checkVal("rst_bus", memAddr | memWdata | {27'b0, memWe, memBe}, 32'd0);
    checkVal("rst_pulses", {29'b0, iValid, dValid, dReady}, 32'd0);
    checkVal("rst_error", {31'b0, error}, 32'd0);
    checkVal("rst_rdata", iRdata | dRdata, 32'd0);
    rstN = 1'b1;
    gnt  = 1'b1;

    // Single fetch: grant immediately, response one cycle later
    iReq = 1'b1; iAddr = 32'h0000_0010;
    step();
    checkVal("fetch_req", {31'b0, memReq}, 32'd1);
    checkVal("fetch_we", {31'b0, memWe}, 32'd0);
    checkVal("fetch_be", {28'b0, memBe}, 32'hF);
    checkVal("fetch_addr", memAddr, 32'h10);
    step();
    checkVal("fetch_req_drop", {31'b0, memReq}, 32'd0);
    checkVal("fetch_no_early_pulse", {31'b0, iValid}, 32'd0);
    rvalid = 1'b1; rdata = 32'h0051_0513;
    step();
    checkVal("fetch_valid", {31'b0, iValid}, 32'd1);
    checkVal("fetch_data", iRdata, 32'h0051_0513);
    iReq = 1'b0; rvalid = 1'b0; rdata = '0;
    step();
    checkVal("fetch_pulse_one_cycle", {31'b0, iValid}, 32'd0);
    checkVal("fetch_data_hold", iRdata, 32'h0051_0513);
    checkVal("fetch_no_regrant", {31'b0, memReq}, 32'd0);

    // Store with partial byte enables
    dReq = 1'b1; dWrite = 1'b1; dAddr = 32'h100; dWdata = 32'hDEAD_BEEF; dBe = 4'b0011;
    step();
    checkVal("st_req_we", {30'b0, memReq, memWe}, 32'd3);
    checkVal("st_addr", memAddr, 32'h100);
    checkVal("st_wdata", memWdata, 32'hDEAD_BEEF);
    checkVal("st_be", {28'b0, memBe}, 32'h3);
    step();
    rvalid = 1'b1;
    step();
    checkVal("st_ready_novalid", {30'b0, dReady, dValid}, 32'd2);
    dReq = 1'b0; dWrite = 1'b0; rvalid = 1'b0;
    step();
    checkVal("st_ready_one_cycle", {31'b0, dReady}, 32'd0);

    // Grant backpressure on a load: request and payload hold, no watchdog
    gnt = 1'b0; dReq = 1'b1; dAddr = 32'h200; dBe = 4'hC;
    step();
    for (int c = 0; c < 5; c++) begin
      checkVal($sformatf("bp_hold_%0d", c), {memReq, memWe, memBe, memAddr[25:0]},
               {1'b1, 1'b0, 4'hC, 26'h200});
      checkVal($sformatf("bp_noerr_%0d", c), {31'b0, error}, 32'd0);
      if (c < 4) step();
    end
    gnt = 1'b1;
    step();
    rvalid = 1'b1; rdata = 32'h1234_5678;
    step();
    checkVal("bp_load_valid", {29'b0, dValid, dReady, error}, 32'd4);
    checkVal("bp_load_data", dRdata, 32'h1234_5678);
    dReq = 1'b0; rvalid = 1'b0;
    step();

    // Contention from reset: I, D, I, D
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    iReq = 1'b1; iAddr = 32'h40; dReq = 1'b1; dWrite = 1'b0; dAddr = 32'h80; dBe = 4'hF;
    step();
    for (int k = 0; k < 4; k++) begin
      checkVal($sformatf("rr_grant_%0d", k), {memReq, memAddr[30:0]},
               (k % 2 == 0) ? 32'h8000_0040 : 32'h8000_0080);
      step();
      rvalid = 1'b1; rdata = 32'hC0DE_0000 + k;
      step();
      rvalid = 1'b0;
      if (k % 2 == 0) begin
        checkVal($sformatf("rr_ipulse_%0d", k), {30'b0, iValid, dValid}, 32'd2);
        checkVal($sformatf("rr_idata_%0d", k), iRdata, 32'hC0DE_0000 + k);
      end else begin
        checkVal($sformatf("rr_dpulse_%0d", k), {30'b0, iValid, dValid}, 32'd1);
        checkVal($sformatf("rr_ddata_%0d", k), dRdata, 32'hC0DE_0000 + k);
      end
      if (k == 3) begin
        iReq = 1'b0; dReq = 1'b0;
      end
      step();
    end

    // Watchdog timeout after 4 WAIT cycles without a response
    iReq = 1'b1; iAddr = 32'h300;
    step();
    checkVal("to_req", {31'b0, memReq}, 32'd1);
    iReq = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      checkVal($sformatf("to_noerr_%0d", c), {31'b0, error}, 32'd0);
      step();
    end
    checkVal("to_error", {31'b0, error}, 32'd1);
    checkVal("to_idle", {31'b0, memReq}, 32'd0);
    checkVal("to_nopulse", {31'b0, iValid}, 32'd0);
    rvalid = 1'b1; rdata = 32'h0000_0BAD;
    step();
    checkVal("to_late_rvalid", {29'b0, iValid, dValid, dReady}, 32'd0);
    checkVal("to_rdata_hold", iRdata, 32'hC0DE_0002);
    rvalid = 1'b0;
    dReq = 1'b1; dWrite = 1'b1; dAddr = 32'h400; dWdata = 32'h1; dBe = 4'h1;
    step();
    checkVal("to_back_in_idle", {memReq, memAddr[30:0]}, 32'h8000_0400);
    step();
    rvalid = 1'b1;
    step();
    checkVal("to_after_ready", {31'b0, dReady}, 32'd1);
    checkVal("to_error_sticky", {31'b0, error}, 32'd1);
    dReq = 1'b0; dWrite = 1'b0; rvalid = 1'b0;
    step();

    // Reset while in WAIT, then a late response
    iReq = 1'b1; iAddr = 32'h500;
    step(); step();
    rstN = 1'b0;
    step();
    checkVal("rw_error_clr", {31'b0, error}, 32'd0);
    checkVal("rw_bus_clr", memAddr | {27'b0, memReq, memBe}, 32'd0);
    checkVal("rw_rdata_clr", iRdata | dRdata, 32'd0);
    rstN = 1'b1; iReq = 1'b0; rvalid = 1'b1; rdata = 32'h77;
    step();
    checkVal("rw_nopulse", {28'b0, iValid, dValid, dReady, memReq}, 32'd0);
    checkVal("rw_rdata_kept", iRdata, 32'd0);
    rvalid = 1'b0;

    // Response in the same cycle the watchdog would expire
    iReq = 1'b1; iAddr = 32'h600;
    step();
    step(); step(); step(); step();
    rvalid = 1'b1; rdata = 32'hA5A5_5A5A;
    step();
    checkVal("sim_valid", {31'b0, iValid}, 32'd1);
    checkVal("sim_data", iRdata, 32'hA5A5_5A5A);
    checkVal("sim_noerr", {31'b0, error}, 32'd0);
    iReq = 1'b0; rvalid = 1'b0;
    step();
    checkVal("sim_noerr_after", {30'b0, error, memReq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between the multi-cycle core's instruction-fetch port and its load/store port.
- Sits between the core and the memory.
- Arbitrates with round-robin priority and keeps at most one transaction outstanding.
- A watchdog flags a memory that stops responding.

Parameters:
- DATAWIDTH, 32, width of data and address buses.
- TIMEOUT_CYCLES, 255, response-wait cycles before error; 1..(2^CNTW)-1.
- CNTW, 8, width of watchdog counter.

Ports:
- ARB_Clk_In  in  1  clock.
- ARB_Reset_In  in  1  reset, synchronous, active-low.
- ARB_I_Req_In  in  1  instruction fetch request (the core's insmem ready output).
- ARB_I_Addr_InBUS  in  DATAWIDTH  fetch address.
- ARB_I_Valid_Out  out  1  fetch data valid, 1-cycle pulse.
- ARB_I_Readdata_OutBUS  out  DATAWIDTH  fetch data.
- ARB_D_Req_In  in  1  data request (the core's datamem valid output).
- ARB_D_Write_In  in  1  1 = store, 0 = load.
- ARB_D_Addr_InBUS  in  DATAWIDTH  data address.
- ARB_D_Writedata_InBUS  in  DATAWIDTH  store data.
- ARB_D_Byteenable_InBUS  in  4  byte enables.
- ARB_D_Ready_Out  out  1  store accepted, 1-cycle pulse.
- ARB_D_Valid_Out  out  1  load data valid, 1-cycle pulse.
- ARB_D_Readdata_OutBUS  out  DATAWIDTH  load data.
- ARB_Mem_Req_Out  out  1  memory request.
- ARB_Mem_We_Out  out  1  memory write enable.
- ARB_Mem_Addr_OutBUS  out  DATAWIDTH  memory address.
- ARB_Mem_Writedata_OutBUS  out  DATAWIDTH  memory write data.
- ARB_Mem_Byteenable_OutBUS  out  4  memory byte enables.
- ARB_Mem_Gnt_In  in  1  memory accepted the request this cycle.
- ARB_Mem_Rvalid_In  in  1  memory response (read data or write ack).
- ARB_Mem_Readdata_InBUS  in  DATAWIDTH  memory read data.
- ARB_Error_Out  out  1  sticky watchdog timeout flag.

Behaviour:
- Reset (ARB_Reset_In=0 at a clock edge):
  - state=IDLE, last_grant=DATA (so the first tie goes to instruction), watchdog=0.
  - All outputs 0, including ARB_Error_Out and the bus registers.
- States: IDLE, REQ, WAIT.
- Sampling:
  - Requests are sampled only in IDLE.
  - A requester must hold req and its payload stable until its Valid/Ready pulse.
  - Request inputs are level-sensitive.
- IDLE:
  - Only I requesting: grant I. Only D requesting: grant D.
  - Both requesting: grant the side opposite last_grant, then update last_grant.
  - On grant: register owner, addr, we (I: 0; D: ARB_D_Write_In), wdata and byteenable (I: 4'b1111), and go to REQ.
  - No request: stay in IDLE.
- REQ:
  - ARB_Mem_Req_Out=1, driven from registers only (no combinational path from request inputs).
  - On ARB_Mem_Gnt_In=1: go to WAIT, clear Req_Out on the next cycle, watchdog=0.
  - Otherwise hold the request; the watchdog does not count in REQ.
- WAIT, on ARB_Mem_Rvalid_In=1:
  - Owner I: ARB_I_Valid_Out=1 for exactly one cycle, ARB_I_Readdata_OutBUS=registered read data.
  - Owner D load: ARB_D_Valid_Out pulse plus read data. Owner D store: ARB_D_Ready_Out pulse.
  - Pulses are registered, asserted the cycle after Rvalid.
  - Go to IDLE. A new grant may occur in IDLE on the cycle the pulse is visible.
  - Minimum latency, request to pulse: IDLE to REQ 1 cycle, Gnt same cycle, Rvalid next cycle, pulse next cycle = 3 cycles.
- WAIT watchdog:
  - Increments each cycle without Rvalid.
  - Reaching TIMEOUT_CYCLES: set ARB_Error_Out (sticky until reset), return to IDLE, no pulse to the owner.
  - The counter saturates and never wraps.
- Rvalid outside WAIT: ignored. Gnt outside REQ: ignored.
- Read data outputs hold their last value between pulses.
- Reset mid-transaction: abandons it immediately. Outputs are 0 next cycle. No pulse for the abandoned transfer.
- Simultaneous Rvalid and timeout in the same cycle: Rvalid wins, no error.

Decomposition:
- Shared package holds:
  - state encoding localparams ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_WAIT=2'd2.
  - owner encoding OWN_I=1'b0, OWN_D=1'b1.
  - byte-enable-all constant 4'b1111.
- One natural sub-module: arb_watchdog (saturating counter with clear, enable, threshold-compare output).
- Arbitration FSM and bus registers stay in the top module.

Test Plan:
- Single fetch:
  - Stimulus: I_Req=1, addr 0x0000_0010; memory Gnt immediately, Rvalid next cycle with 0x0051_0513.
  - Response: Mem_Req 1 cycle, We=0, BE=4'b1111; I_Valid pulse 3 cycles after request with data 0x0051_0513.
- Contention round-robin:
  - Stimulus: I_Req and D_Req both held high from reset, each request dropped one cycle after its pulse and re-raised.
  - Response: grants alternate I, D, I, D; the first grant goes to I.
- Store:
  - Stimulus: D_Req=1, Write=1, addr 0x100, wdata 0xDEAD_BEEF, BE 4'b0011.
  - Response: memory sees exactly these values with We=1; D_Ready pulses once; D_Valid stays 0.
- Gnt backpressure:
  - Stimulus: Gnt held 0 for 5 cycles.
  - Response: Mem_Req and payload stable for all 5 cycles; Error stays 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4; Gnt given, no Rvalid.
  - Response: Error=1 after 4 WAIT cycles; FSM back in IDLE; no pulse; Error cleared only by reset.
- Reset mid-WAIT:
  - Stimulus: assert ARB_Reset_In=0 for one edge during WAIT, then raise Rvalid.
  - Response: all outputs 0; late Rvalid ignored; no pulse.
